delay_line: RTL and testbench

Programmable integer-cycle delay for the feedback path, sitting directly downstream of `coarse_gain_and_limiter` and ahead of the DAC output register. It sets the feedback phase by delaying the limited signal by a run-time selectable number of clock cycles, 0 to 2^ADDR_WIDTH−1. A circular buffer in block RAM provides the delay. A fill tracker blanks the output until the buffer holds valid history, both after reset and after any delay change.

---
 rtl/pt_feedback_pkg.sv | 18 +
 rtl/delay_line_if.sv | 30 +++
 rtl/delay_ram.sv | 35 +++
 rtl/delay_line.sv | 134 +++++++++++++
 tb/tb_delay_line.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/pt_feedback_pkg.sv
// Shared definitions for the feedback-path blocks: default widths, the
// delay-line fill/run state type and the maximum-delay helper.
package pt_feedback_pkg;

  localparam int DATA_WIDTH_DEF = 14;
  localparam int ADDR_WIDTH_DEF = 10;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } delay_state_t;

  // Largest delay a buffer with the given address width can provide.
  function automatic int unsigned max_delay(input int unsigned addr_width);
    return (32'd1 << addr_width) - 32'd1;
  endfunction

endpackage

// File: rtl/delay_line_if.sv
// Sample/delay bundle between the gain stage, the delay line and the DAC
// output register. The master drives delay and samples, the slave returns
// the delayed stream and its valid flag.
interface delay_line_if
  import pt_feedback_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic        [ADDR_WIDTH-1:0] delay_i;
  logic signed [DATA_WIDTH-1:0] data_i;
  logic signed [DATA_WIDTH-1:0] data_o;
  logic                         valid_o;

  modport master (
    output delay_i,
    output data_i,
    input  data_o,
    input  valid_o
  );

  modport slave (
    input  delay_i,
    input  data_i,
    output data_o,
    output valid_o
  );

endinterface

// File: rtl/delay_ram.sv
// Simple dual-port buffer memory: one write port, one synchronous read port.
// No reset so that it maps onto block RAM; stale contents are masked by the
// fill tracker in the delay line.
module delay_ram #(
  parameter int DATA_WIDTH = 14,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                         clk_i,
  input  logic                         we_i,
  input  logic        [ADDR_WIDTH-1:0] waddr_i,
  input  logic signed [DATA_WIDTH-1:0] wdata_i,
  input  logic        [ADDR_WIDTH-1:0] raddr_i,
  output logic signed [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic signed [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
  logic signed [DATA_WIDTH-1:0] rdata_q;

  // Write port: store the incoming sample at the write pointer.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: registered read, one cycle from address to data.
  always_ff @(posedge clk_i) begin
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/delay_line.sv
// Programmable integer-cycle delay for the feedback path. A circular buffer
// delays the limited signal by delay_i cycles (total latency delay_i + 1);
// a fill tracker blanks the output until the buffer holds valid history
// after reset or after any change of the requested delay.
module delay_line
  import pt_feedback_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  delay_line_if.slave  bus
);

  logic        [ADDR_WIDTH-1:0] wr_ptr_q;
  logic        [ADDR_WIDTH-1:0] wr_ptr_d;
  logic        [ADDR_WIDTH-1:0] delay_q;
  logic        [ADDR_WIDTH-1:0] fill_cnt_q;
  logic        [ADDR_WIDTH-1:0] fill_cnt_d;
  logic        [ADDR_WIDTH-1:0] rd_addr_s;
  delay_state_t                 state_q;
  delay_state_t                 state_d;
  logic                         delay_chg_s;
  logic signed [DATA_WIDTH-1:0] din_q;
  logic signed [DATA_WIDTH-1:0] rd_data_s;
  logic signed [DATA_WIDTH-1:0] data_o_q;
  logic signed [DATA_WIDTH-1:0] data_o_d;
  logic                         valid_o_q;
  logic                         valid_o_d;

  // Pointer arithmetic and change detection. The read address is issued one
  // cycle before the output register loads, so subtracting the delay from the
  // current write pointer lands on the sample written D cycles earlier; the
  // subtraction wraps naturally modulo the buffer depth.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(1'b1);
    rd_addr_s   = wr_ptr_q - delay_q;
    delay_chg_s = (bus.delay_i != delay_q);
  end

  // Fill tracker. A change counts its own edge as fill cycle 0, so the new
  // delay D' releases the output exactly D'+1 edges after the change; the
  // register therefore restarts at 1 (or goes straight to RUN for D' = 0).
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    if (delay_chg_s) begin
      if (bus.delay_i == '0) begin
        state_d    = RUN;
        fill_cnt_d = '0;
      end else begin
        state_d    = FILL;
        fill_cnt_d = ADDR_WIDTH'(1'b1);
      end
    end else begin
      case (state_q)
        FILL: begin
          if (fill_cnt_q == delay_q) begin
            state_d    = RUN;
            fill_cnt_d = '0;
          end else begin
            state_d    = FILL;
            fill_cnt_d = fill_cnt_q + ADDR_WIDTH'(1'b1);
          end
        end
        RUN: begin
          state_d    = RUN;
          fill_cnt_d = fill_cnt_q;
        end
        default: begin
          state_d    = FILL;
          fill_cnt_d = '0;
        end
      endcase
    end
  end

  // Output selection. D = 0 takes the bypass register rather than relying on
  // read-during-write behaviour of the RAM; a change blanks its own edge.
  always_comb begin
    data_o_d  = '0;
    valid_o_d = 1'b0;
    if ((state_q == RUN) && !delay_chg_s) begin
      valid_o_d = 1'b1;
      if (delay_q == '0) begin
        data_o_d = din_q;
      end else begin
        data_o_d = rd_data_s;
      end
    end else begin
      data_o_d  = '0;
      valid_o_d = 1'b0;
    end
  end

  // State, pointer and output registers. Reset loads delay_q from delay_i so
  // that leaving reset is never seen as a delay change.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      delay_q    <= bus.delay_i;
      fill_cnt_q <= '0;
      state_q    <= FILL;
      din_q      <= '0;
      data_o_q   <= '0;
      valid_o_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      delay_q    <= bus.delay_i;
      fill_cnt_q <= fill_cnt_d;
      state_q    <= state_d;
      din_q      <= bus.data_i;
      data_o_q   <= data_o_d;
      valid_o_q  <= valid_o_d;
    end
  end

  delay_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (!rst_i),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_i),
    .raddr_i (rd_addr_s),
    .rdata_o (rd_data_s)
  );

  assign bus.data_o  = data_o_q;
  assign bus.valid_o = valid_o_q;

endmodule

// File: tb/tb_delay_line.sv
// Directed testbench for delay_line. Edge e is the e-th rising edge after
// reset release (edge 0 = first edge with rst low). Inputs are set #1 after
// an edge, outputs are checked #1 after the next edge.
module tb_delay_line;
  import pt_feedback_pkg::*;

  localparam int DW = 14;
  localparam int AW = 10;
  localparam logic signed [DW-1:0] MIN_S = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] MAX_S = {1'b0, {(DW-1){1'b1}}};

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #4 clk = ~clk;

  delay_line_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  delay_line #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Stimulus patterns: 0 = ramp +100, 1 = ramp +1, other = alternating min/max.
  function automatic logic signed [DW-1:0] samp(input int md, input int e);
    case (md)
      0:       return DW'(100 * e);
      1:       return DW'(e);
      default: return (e % 2 == 0) ? MIN_S : MAX_S;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int d);
    rst         = 1'b1;
    bus.delay_i = AW'(d);
    bus.data_i  = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(0);
    n_cmp++;
    if (bus.valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset valid_o got %0b want 0", bus.valid_o);
    end
    n_cmp++;
    if (bus.data_o !== '0) begin
      n_bad++;
      $display("FAIL reset data_o got %0d want 0", bus.data_o);
    end
  endtask

  // Steady delay d from reset with pattern md for n edges.
  task automatic test_steady(input string name, input int d, input int md, input int n);
    logic                 exp_v;
    logic signed [DW-1:0] exp_d;
    do_reset(d);
    for (int e = 0; e < n; e++) begin
      bus.data_i = samp(md, e);
      tick();
      exp_v = (e >= d + 1);
      exp_d = exp_v ? samp(md, e - d - 1) : '0;
      n_cmp++;
      if (bus.valid_o !== exp_v) begin
        n_bad++;
        $display("FAIL %s e=%0d valid_o got %0b want %0b", name, e, bus.valid_o, exp_v);
      end
      n_cmp++;
      if (bus.data_o !== exp_d) begin
        n_bad++;
        $display("FAIL %s e=%0d data_o got %0d want %0d", name, e, bus.data_o, exp_d);
      end
    end
  endtask

  // 5 -> 10 at edge 20; then 10 -> 12 at 40 and 12 -> 2 at 45 (change in FILL).
  task automatic test_delay_change();
    int                   d_now;
    int                   lc;
    logic                 exp_v;
    logic signed [DW-1:0] exp_d;
    do_reset(5);
    d_now = 5;
    lc    = 0;
    for (int e = 0; e < 60; e++) begin
      if (e == 20) begin d_now = 10; lc = e; end
      if (e == 40) begin d_now = 12; lc = e; end
      if (e == 45) begin d_now = 2;  lc = e; end
      bus.delay_i = AW'(d_now);
      bus.data_i  = samp(0, e);
      tick();
      exp_v = (e >= lc + d_now + 1);
      exp_d = exp_v ? samp(0, e - d_now - 1) : '0;
      n_cmp++;
      if (bus.valid_o !== exp_v) begin
        n_bad++;
        $display("FAIL delay_change e=%0d valid_o got %0b want %0b", e, bus.valid_o, exp_v);
      end
      n_cmp++;
      if (bus.data_o !== exp_d) begin
        n_bad++;
        $display("FAIL delay_change e=%0d data_o got %0d want %0d", e, bus.data_o, exp_d);
      end
    end
  endtask

  // One-cycle reset pulse while running at D = 3, then refill with a new pattern.
  task automatic test_reset_mid_run();
    logic                 exp_v;
    logic signed [DW-1:0] exp_d;
    do_reset(3);
    for (int e = 0; e < 10; e++) begin
      bus.data_i = samp(0, e);
      tick();
    end
    n_cmp++;
    if (bus.valid_o !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset pre valid_o got %0b want 1", bus.valid_o);
    end
    do_reset(3);
    n_cmp++;
    if (bus.valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset pulse valid_o got %0b want 0", bus.valid_o);
    end
    n_cmp++;
    if (bus.data_o !== '0) begin
      n_bad++;
      $display("FAIL mid_reset pulse data_o got %0d want 0", bus.data_o);
    end
    for (int e = 0; e < 12; e++) begin
      bus.data_i = samp(1, e + 500);
      tick();
      exp_v = (e >= 4);
      exp_d = exp_v ? samp(1, e - 4 + 500) : '0;
      n_cmp++;
      if (bus.valid_o !== exp_v) begin
        n_bad++;
        $display("FAIL mid_reset e=%0d valid_o got %0b want %0b", e, bus.valid_o, exp_v);
      end
      n_cmp++;
      if (bus.data_o !== exp_d) begin
        n_bad++;
        $display("FAIL mid_reset e=%0d data_o got %0d want %0d", e, bus.data_o, exp_d);
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.delay_i = '0;
    bus.data_i  = '0;
    test_reset();
    test_steady("d0_ramp", 0, 0, 12);
    test_steady("d5_ramp", 5, 0, 20);
    test_steady("dmax_ramp", int'(max_delay(AW)), 1, 3000);
    test_delay_change();
    test_reset_mid_run();
    test_steady("d7_alt", 7, 2, 30);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
